fpu_round_pipe: RTL and testbench
=================================

// Module: fpu_round_pipe
// PURPOSE
// Parametrised, 2-stage pipelined rounder/packer for the FPU result path. Takes an unbiased
// exponent and a normalised mantissa with guard/sticky bits, and rounds per the FPSCR mode (RN or
// RTZ). Packs to IEEE format and raises overflow/underflow/inexact. Valid/ready on both sides,
// plus a sticky flag accumulator for FPSCR.FLAG update.
// PARAMETERS
// EXP_W     8   packed exponent width (11 for double)
// FRAC_W    23  packed fraction width (52 for double)
// IN_EXP_W  11  signed unbiased input exponent width; must be >= EXP_W+1
// PORTS
// clk         in   1              clock
// rst         in   1              asynchronous, active-high reset
// i_valid     in   1              input beat valid
// i_ready     out  1              input accepted when i_valid && i_ready
// i_rm        in   1              0 = round-to-nearest-even, 1 = round-to-zero
// i_sign      in   1              result sign
// i_exp       in   IN_EXP_W       signed unbiased exponent, mantissa = 1.frac
// i_frac      in   FRAC_W+2       {fraction, guard, sticky}
// i_is_zero   in   1              special: zero
// i_is_inf    in   1              special: infinity
// i_is_nan    in   1              special: NaN (priority over zero/inf)
// o_valid     out  1              output beat valid
// o_ready     in   1              downstream accepts
// o_val       out  1+EXP_W+FRAC_W packed {sign, exp, frac}
// o_flags     out  3              {overflow, underflow, inexact} of this beat
// i_flag_clr  in   1              clear accumulator
// o_flags_acc out  3              OR of o_flags over all output handshakes since clear/reset
// BEHAVIOUR
// - Reset (async, immediate): s1/s2 valid=0, o_valid=0, o_val=0, o_flags=0, o_flags_acc=0.
//   Reset mid-operation drops in-flight beats; no output for them.
// - Latency 2 cycles from input handshake to o_valid with no stall; throughput 1/cycle.
// - Stage advance: s2 loads when !s2_valid || o_ready. s1 loads when !s1_valid || s2 loads.
//   i_ready = s1 load condition (combinational from o_ready, no input dependence). Held output is
//   stable while o_valid && !o_ready. Two beats are buffered under full stall; no loss, no dup.
// - Stage 1: biased = sext(i_exp) + (2^(EXP_W-1)-1) in IN_EXP_W+2 bits. G=i_frac[1], S=i_frac[0].
//   inc = RN ? G & (S | frac_lsb) : 0. inexact_raw = G|S.
// - Stage 2 (mutually exclusive, priority order):
//   NaN: exp all-ones, frac = {0, all-ones}, sign kept, flags 0.
//   Inf: exp all-ones, frac 0, flags 0. Zero: exp 0, frac 0, sign kept, flags 0.
//   biased <= 0: flush to signed zero; underflow=1, inexact=1 (no denormal output).
//   Otherwise, the rounded frac is frac+inc. A carry-out gives frac=0 and exp=biased+1.
//   If the final exp >= 2^EXP_W-1, the result overflows: overflow=1, inexact=1.
//   Overflowed result: RN -> inf; RTZ -> max finite (exp all-ones minus 1, frac all-ones).
//   Else normal pack; inexact=inexact_raw.
// - Accumulator: on o_valid&&o_ready, acc |= o_flags. If i_flag_clr in the same cycle, acc =
//   o_flags of that beat (clear first, then OR). Clear alone sets acc=0.
// TESTING
// 1) RN, exp 0, frac 0, G=1 S=0 -> 0x3F800000 (tie to even), flags 3'b001.
// 2) RN, exp 0, frac 0, G=1 S=1 -> 0x3F800001; RTZ same -> 0x3F800000, inexact.
// 3) RN, exp 0, frac all-ones, G=1 -> 0x40000000 (carry into exp), inexact.
// 4) exp 128: RN -> 0x7F800000, RTZ -> 0x7F7FFFFF, flags 3'b101.
//    exp 127 frac all-ones G=1 RN -> 0x7F800000, overflow.
// 5) sign=1, exp -127 -> 0x80000000, flags 3'b011; NaN in -> 0x7FBFFFFF (sign 0), flags 0.
// 6) 4 back-to-back inputs, o_ready=0 for 3 cycles: i_ready drops after 2 accepted. Then in-order
//    outputs with no loss. i_flag_clr with an inexact output in the same cycle -> acc=3'b001.
//    Reset asserted mid-stream -> o_valid=0 at once.

Source files
------------

// File: rtl/fpu_round_pipe.sv
// Two-stage rounder/packer for the FPU result path: RN/RTZ rounding, IEEE packing,
// overflow/underflow/inexact flags and a sticky flag accumulator.
module fpu_round_pipe #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned FRAC_W   = 23,
  parameter int unsigned IN_EXP_W = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic                      i_rm,
  input  logic                      i_sign,
  input  logic [IN_EXP_W-1:0]       i_exp,
  input  logic [FRAC_W+1:0]         i_frac,
  input  logic                      i_is_zero,
  input  logic                      i_is_inf,
  input  logic                      i_is_nan,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [EXP_W+FRAC_W:0]     o_val,
  output logic [2:0]                o_flags,
  input  logic                      i_flag_clr,
  output logic [2:0]                o_flags_acc
);

  localparam int unsigned BW    = IN_EXP_W + 2;
  localparam int unsigned VAL_W = 1 + EXP_W + FRAC_W;

  localparam logic [BW-1:0]     BIAS     = BW'((1 << (EXP_W - 1)) - 1);
  localparam logic [BW-1:0]     EXP_TOP  = BW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]  EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  EXP_MAXF = EXP_W'((1 << EXP_W) - 2);
  localparam logic [FRAC_W-1:0] FRAC_ONE = {FRAC_W{1'b1}};

  typedef struct packed {
    logic              sign;
    logic              rm;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
    logic [BW-1:0]     biased;
    logic [FRAC_W-1:0] frac;
    logic              inc;
    logic              inexact_raw;
  } s1_t;

  logic              s1_load_c;
  logic              s2_load_c;
  logic              s1_valid_d, s1_valid_q;
  s1_t               s1_d, s1_q;
  logic              s2_valid_d, s2_valid_q;
  logic [VAL_W-1:0]  val_d, val_q;
  logic [2:0]        flags_d, flags_q;
  logic [2:0]        acc_d, acc_q;
  logic [FRAC_W:0]   sum_c;
  logic [BW-1:0]     exp_c;
  logic              ovf_c;

  // Pipeline advance: a stage loads when empty or when its successor loads.
  always_comb begin
    s2_load_c = !s2_valid_q || o_ready;
    s1_load_c = !s1_valid_q || s2_load_c;
  end

  assign i_ready = s1_load_c;

  // Stage 1: bias the exponent and decide the rounding increment.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_load_c) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_d.sign        = i_sign;
        s1_d.rm          = i_rm;
        s1_d.is_nan      = i_is_nan;
        s1_d.is_inf      = i_is_inf;
        s1_d.is_zero     = i_is_zero;
        s1_d.biased      = {{2{i_exp[IN_EXP_W-1]}}, i_exp} + BIAS;
        s1_d.frac        = i_frac[FRAC_W+1:2];
        s1_d.inc         = !i_rm && i_frac[1] && (i_frac[0] || i_frac[2]);
        s1_d.inexact_raw = i_frac[1] || i_frac[0];
      end
    end
  end

  // Stage 2: apply the increment, handle specials/range and pack.
  always_comb begin
    sum_c      = {1'b0, s1_q.frac} + (FRAC_W+1)'(s1_q.inc);
    exp_c      = s1_q.biased + BW'(sum_c[FRAC_W]);
    ovf_c      = $signed(exp_c) >= $signed(EXP_TOP);
    s2_valid_d = s2_valid_q;
    val_d      = val_q;
    flags_d    = flags_q;
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        flags_d = 3'b000;
        if (s1_q.is_nan) begin
          val_d = {s1_q.sign, EXP_ONES, 1'b0, FRAC_ONE[FRAC_W-2:0]};
        end else if (s1_q.is_inf) begin
          val_d = {s1_q.sign, EXP_ONES, FRAC_W'(0)};
        end else if (s1_q.is_zero) begin
          val_d = {s1_q.sign, EXP_W'(0), FRAC_W'(0)};
        end else if ($signed(s1_q.biased) <= $signed(BW'(0))) begin
          // No denormal output: tiny results flush to signed zero.
          val_d   = {s1_q.sign, EXP_W'(0), FRAC_W'(0)};
          flags_d = 3'b011;
        end else if (ovf_c) begin
          flags_d = 3'b101;
          val_d   = s1_q.rm ? {s1_q.sign, EXP_MAXF, FRAC_ONE}
                            : {s1_q.sign, EXP_ONES, FRAC_W'(0)};
        end else begin
          val_d   = {s1_q.sign, exp_c[EXP_W-1:0], sum_c[FRAC_W-1:0]};
          flags_d = {2'b00, s1_q.inexact_raw};
        end
      end
    end
  end

  // Sticky accumulator: a same-cycle clear happens before the beat's flags are ORed in.
  always_comb begin
    acc_d = acc_q;
    if (i_flag_clr) begin
      acc_d = 3'b000;
    end
    if (s2_valid_q && o_ready) begin
      acc_d = acc_d | flags_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      val_q      <= '0;
      flags_q    <= 3'b000;
      acc_q      <= 3'b000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      val_q      <= val_d;
      flags_q    <= flags_d;
      acc_q      <= acc_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_val       = val_q;
  assign o_flags     = flags_q;
  assign o_flags_acc = acc_q;

endmodule

// File: tb/tb_fpu_round_pipe.sv
// Randomised scoreboard bench for fpu_round_pipe (single precision) with directed corner beats.
module tb_fpu_round_pipe;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned IN_EXP_W = 11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_valid, i_ready, i_rm, i_sign;
  logic [IN_EXP_W-1:0]   i_exp;
  logic [FRAC_W+1:0]     i_frac;
  logic                  i_is_zero, i_is_inf, i_is_nan;
  logic                  o_valid, o_ready;
  logic [EXP_W+FRAC_W:0] o_val;
  logic [2:0]            o_flags;
  logic                  i_flag_clr;
  logic [2:0]            o_flags_acc;

  fpu_round_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .IN_EXP_W(IN_EXP_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_rm(i_rm),
    .i_sign(i_sign), .i_exp(i_exp), .i_frac(i_frac), .i_is_zero(i_is_zero),
    .i_is_inf(i_is_inf), .i_is_nan(i_is_nan), .o_valid(o_valid), .o_ready(o_ready),
    .o_val(o_val), .o_flags(o_flags), .i_flag_clr(i_flag_clr), .o_flags_acc(o_flags_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [2:0]  f;
  } exp_t;

  exp_t        q[$];
  logic [31:0] nxt_v;
  logic [2:0]  nxt_f;
  logic [2:0]  acc_m;
  bit          held;
  logic [31:0] held_v;
  logic [2:0]  held_f;
  bit          last_ihs;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer mantissa rounding straight from the IEEE rules.
  task automatic model(input bit rm, input bit sign, input int e, input logic [22:0] f,
                       input bit g, input bit s, input bit nan, input bit inf, input bit zero,
                       output logic [31:0] v, output logic [2:0] fl);
    int     be;
    longint m;
    be = e + 127;
    fl = 3'b000;
    if (nan)       v = {sign, 8'hFF, 23'h3FFFFF};
    else if (inf)  v = {sign, 8'hFF, 23'h0};
    else if (zero) v = {sign, 31'h0};
    else if (be <= 0) begin
      v  = {sign, 31'h0};
      fl = 3'b011;
    end else begin
      m = longint'(1 << 23) + longint'(f);
      if (!rm && g && (s || (m % 2 == 1))) m = m + 1;
      if (m >= longint'(1 << 24)) begin
        m  = m / 2;
        be = be + 1;
      end
      if (be >= 255) begin
        fl = 3'b101;
        v  = rm ? {sign, 8'hFE, 23'h7FFFFF} : {sign, 8'hFF, 23'h0};
      end else begin
        v  = {sign, 8'(be), 23'(m)};
        fl = {2'b00, g | s};
      end
    end
  endtask

  task automatic set_beat(input bit rm, input bit sign, input int e, input logic [22:0] f,
                          input bit g, input bit s, input bit nan, input bit inf, input bit zero);
    i_rm = rm; i_sign = sign; i_exp = IN_EXP_W'(e); i_frac = {f, g, s};
    i_is_nan = nan; i_is_inf = inf; i_is_zero = zero;
    model(rm, sign, e, f, g, s, nan, inf, zero, nxt_v, nxt_f);
  endtask

  task automatic rand_beat();
    int          sel, e;
    logic [22:0] f;
    sel = int'($urandom_range(0, 15));
    if (sel < 10)       e = int'($urandom_range(0, 260)) - 130;
    else if (sel < 12)  e = int'($urandom_range(0, 2047)) - 1024;
    else if (sel == 12) e = 127 + int'($urandom_range(0, 1));
    else                e = -127 + int'($urandom_range(0, 1));
    f = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
    set_beat(1'($urandom), 1'($urandom), e, f, 1'($urandom), 1'($urandom),
             $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 19) == 0);
  endtask

  // One clock: entered and left at a falling edge, inputs already driven.
  task automatic cycle();
    exp_t e;
    bit   ohs, ihs;
    e.v = '0;
    e.f = '0;
    #1;
    chk("acc", 64'(o_flags_acc), 64'(acc_m));
    if (held) begin
      chk("hold_valid", 64'(o_valid), 64'(1));
      chk("hold_val", 64'(o_val), 64'(held_v));
      chk("hold_flags", 64'(o_flags), 64'(held_f));
    end
    ohs = o_valid && o_ready;
    ihs = i_valid && i_ready;
    if (ohs) begin
      if (q.size() == 0) chk("spurious_out", 64'(1), 64'(0));
      else begin
        e = q.pop_front();
        chk("val", 64'(o_val), 64'(e.v));
        chk("flags", 64'(o_flags), 64'(e.f));
      end
      acc_m = (i_flag_clr ? 3'b000 : acc_m) | e.f;
    end else if (i_flag_clr) begin
      acc_m = 3'b000;
    end
    if (ihs) q.push_back('{nxt_v, nxt_f});
    held     = o_valid && !o_ready;
    held_v   = o_val;
    held_f   = o_flags;
    last_ihs = ihs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_dir(input bit rm, input bit sign, input int e, input logic [22:0] f,
                          input bit g, input bit s, input bit nan, input bit inf,
                          input bit zero, input logic [31:0] v, input logic [2:0] fl);
    bit ok;
    set_beat(rm, sign, e, f, g, s, nan, inf, zero);
    nxt_v   = v;
    nxt_f   = fl;
    i_valid = 1'b1;
    ok      = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      cycle();
      ok = last_ihs;
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 12 && (q.size() != 0 || o_valid); k++) cycle();
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; i_flag_clr = 1'b0;
    i_rm = 1'b0; i_sign = 1'b0; i_exp = '0; i_frac = '0;
    i_is_zero = 1'b0; i_is_inf = 1'b0; i_is_nan = 1'b0;
    acc_m = 3'b000; held = 1'b0; last_ihs = 1'b0; nxt_v = '0; nxt_f = '0;
    #3;
    chk("rst_o_valid", 64'(o_valid), 64'(0));
    chk("rst_o_val", 64'(o_val), 64'(0));
    chk("rst_o_flags", 64'(o_flags), 64'(0));
    chk("rst_acc", 64'(o_flags_acc), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner beats with literal IEEE results.
    send_dir(0, 0,    0, 23'h0,      0, 0, 0, 0, 0, 32'h3F800000, 3'b000);
    send_dir(0, 0,    0, 23'h0,      1, 0, 0, 0, 0, 32'h3F800000, 3'b001);
    send_dir(0, 0,    0, 23'h0,      1, 1, 0, 0, 0, 32'h3F800001, 3'b001);
    send_dir(1, 0,    0, 23'h0,      1, 1, 0, 0, 0, 32'h3F800000, 3'b001);
    send_dir(0, 0,    0, 23'h7FFFFF, 1, 0, 0, 0, 0, 32'h40000000, 3'b001);
    send_dir(0, 0,  128, 23'h0,      0, 0, 0, 0, 0, 32'h7F800000, 3'b101);
    send_dir(1, 0,  128, 23'h0,      0, 0, 0, 0, 0, 32'h7F7FFFFF, 3'b101);
    send_dir(0, 0,  127, 23'h7FFFFF, 1, 0, 0, 0, 0, 32'h7F800000, 3'b101);
    send_dir(0, 1, -127, 23'h0,      0, 0, 0, 0, 0, 32'h80000000, 3'b011);
    send_dir(0, 0,    5, 23'h0,      0, 0, 1, 1, 1, 32'h7FBFFFFF, 3'b000);
    send_dir(0, 1,    5, 23'h0,      0, 0, 0, 1, 0, 32'hFF800000, 3'b000);
    send_dir(0, 1,    5, 23'h0,      0, 0, 0, 0, 1, 32'h80000000, 3'b000);
    drain();

    // Clear in the same cycle as an inexact beat leaves only that beat's flags.
    send_dir(0, 0,    0, 23'h0,      1, 0, 0, 0, 0, 32'h3F800000, 3'b001);
    cycle();
    chk("clr_beat_valid", 64'(o_valid), 64'(1));
    i_flag_clr = 1'b1;
    cycle();
    i_flag_clr = 1'b0;
    chk("clr_with_beat", 64'(o_flags_acc), 64'(3'b001));
    i_flag_clr = 1'b1;
    cycle();
    i_flag_clr = 1'b0;
    chk("clr_alone", 64'(o_flags_acc), 64'(3'b000));

    // Full stall: exactly two beats are absorbed, then all four emerge in order.
    o_ready = 1'b0;
    i_valid = 1'b1;
    n_acc   = 0;
    rand_beat();
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (last_ihs) begin
        n_acc++;
        rand_beat();
      end
    end
    chk("stall_accepts", 64'(n_acc), 64'(2));
    chk("stall_i_ready", 64'(i_ready), 64'(0));
    o_ready = 1'b1;
    for (int k = 0; k < 10 && n_acc < 4; k++) begin
      cycle();
      if (last_ihs) begin
        n_acc++;
        if (n_acc < 4) rand_beat();
      end
    end
    chk("stall_total", 64'(n_acc), 64'(4));
    drain();

    // Randomised traffic with backpressure and occasional clears.
    last_ihs = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_valid || last_ihs) begin
        i_valid = $urandom_range(0, 3) != 0;
        if (i_valid) rand_beat();
      end
      o_ready    = $urandom_range(0, 3) != 0;
      i_flag_clr = $urandom_range(0, 15) == 0;
      cycle();
    end
    i_flag_clr = 1'b0;
    drain();

    // Reset in the middle of a stalled stream drops everything at once.
    o_ready = 1'b0;
    i_valid = 1'b1;
    rand_beat();
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (last_ihs) rand_beat();
    end
    chk("pre_rst_valid", 64'(o_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_o_valid", 64'(o_valid), 64'(0));
    chk("mid_rst_o_val", 64'(o_val), 64'(0));
    chk("mid_rst_acc", 64'(o_flags_acc), 64'(0));
    q.delete();
    acc_m   = 3'b000;
    held    = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_dir(0, 0, 1, 23'h0, 0, 1, 0, 0, 0, 32'h40000000, 3'b001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
